video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Parametrised raster timing and character-cell address generator for the NTSC composite path. It replaces the fixed-constant H/V counters and the cell address logic embedded in the video block with one reusable block. Geometry, pixel divider, cell size, column and row counts are all parameters. New behaviour is optional 2-field interlace (alternating 262/263-line fields) and a per-frame row-scroll offset. It sits between the pixel clock domain and the VRAM/CG/shift-register pipeline, and drives their address and strobe inputs.

## Interface
Parameters:
- H_TOTAL, 2038: clocks per line
- HS_WID, 150: H sync width in clocks
- CB_ST, 168: colorburst start, in hcnt
- CB_ND, 248: colorburst end, exclusive
- ASTART, 371: hcnt of the first active clock
- PIX_DIV, 6: clocks per pixel
- CELL_W, 8: pixels per cell
- COLS, 32: cells per line
- CELL_H, 8: lines per cell
- ROWS, 25: cell rows
- V_TOTAL, 262: lines in field 0; field 1 has V_TOTAL+1 when interlaced
- BK_TOP, 16: first active line
- VS_LIN, 248: vsync line
- VS_WID, 1888: vsync width in clocks
- Derived widths: HA_W=$clog2(COLS), CL_W=$clog2(CELL_H), VA_W=$clog2(ROWS)

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- interlace  in  1  interlace request; sampled at frame start
- start_row  in  VA_W  first displayed row; sampled at frame start
- hs_n  out  1  H sync, active low
- vs_n  out  1  V sync, active low
- cb  out  1  colorburst gate
- active  out  1  active video window
- pixena  out  1  pixel-rate enable
- vload  out  1  load shift register, qualified by pixena
- haddr  out  HA_W  cell column
- cline  out  CL_W  line within cell
- vaddr  out  VA_W  cell row
- field  out  1  current field, always 0 when not interlaced
- line_start  out  1  one-clock strobe per line
- frame_start  out  1  one-clock strobe per field

## Operation
- Internal counters: hcnt runs 0..H_TOTAL-1. vcnt runs 0..VMAX, where VMAX = V_TOTAL-1, or V_TOTAL when field_sh=1.
- Shadow registers interlace_sh and row_sh load from the inputs when hcnt wraps and vcnt wraps to 0. The inputs have no effect at any other time.
- field toggles at each field wrap when interlace_sh=1. It is forced to 0 when interlace_sh=0.
- Decodes:
  - hs_n=0 while hcnt<HS_WID.
  - vs_n=0 while vcnt==VS_LIN && hcnt<VS_WID.
  - cb=1 while CB_ST≤hcnt<CB_ND.
  - line_start=1 at hcnt==0.
  - frame_start=1 at hcnt==0 && vcnt==0.
- Active lines are BK_TOP ≤ vcnt < BK_TOP+ROWS*CELL_H. On an active line, active rises at hcnt==ASTART and stays high for exactly COLS*CELL_W*PIX_DIV clocks.
- Pixel and cell counting:
  - A divider dcnt runs 0..PIX_DIV-1, reset to 0 at ASTART.
  - pixena=1 when dcnt==0 inside active.
  - A pixel counter pcnt runs 0..CELL_W-1. vload=pixena && pcnt==0.
  - haddr resets to 0 at ASTART and increments after the last pixel of each cell. It wraps to 0 after COLS-1.
- Vertical cell addressing:
  - At vcnt==BK_TOP: cline=0, vaddr=row_sh.
  - At the end of each active line, cline increments.
  - When cline==CELL_H-1, cline wraps to 0 and vaddr increments. vaddr wraps from ROWS-1 to 0; this is a modulo-ROWS add, not a power-of-two wrap.
- haddr, cline and vaddr hold their values outside active.

## Timing
- All outputs are registered. The value for count n appears on the clock after hcnt==n, which gives 1-cycle latency from the counters.
- Reset values:
  - hcnt, vcnt, dcnt, pcnt = 0.
  - hs_n=1, vs_n=1.
  - cb, active, pixena, vload, line_start, frame_start, field, haddr, cline, vaddr = 0.
  - interlace_sh=0, row_sh=0.
- After reset deasserts, the first clock counts hcnt=0, vcnt=0. line_start and frame_start pulse on the following clock.
- Reset asserted mid-line clears all state immediately. There is no partial-line recovery.
- Simultaneous events:
  - The field wrap and the shadow load occur on the same clock.
  - A start_row change on that clock is taken.
  - A change one clock later waits a full field.
- Elaboration-time assertions:
  - ASTART + COLS*CELL_W*PIX_DIV ≤ H_TOTAL
  - BK_TOP + ROWS*CELL_H ≤ VS_LIN
  - CB_ND ≤ ASTART
  - PIX_DIV ≥ 2

## Structure
- Package video_pkg holds:
  - the NTSC default timing constants listed above;
  - a PAL-60 alternate set;
  - the derived-width functions.
- One sub-module, video_cell_addr, holds the dcnt/pcnt/haddr/cline/vaddr logic including the modulo-ROWS add. The top holds the H/V counters, the decodes and the shadow registers.

## Test plan
- Reset release with defaults: all outputs at their reset values. First line_start and frame_start appear 1 clock after release. hs_n is low for 150 clocks of every 2038.
- Non-interlaced frame: exactly 262 line_start pulses between frame_start pulses. vs_n is low for 1888 clocks only on line 248. active is high 200 lines × 1536 clocks. pixena count per line = 256. vload count per line = 32.
- interlace=1: field lengths alternate 262, 263, 262. field toggles at each frame_start. Deasserting interlace mid-field takes effect at the next wrap, and field then returns to 0.
- Scroll: start_row=24 with ROWS=25. On line 16, vaddr=24. After 8 active lines vaddr=0, with no value 25..31 ever presented.
- Mid-field start_row change from 0 to 5 at line 100: vaddr sequence unchanged for that field. The next field starts at vaddr=5.
- Reset asserted asynchronously at hcnt≈1000 of an active line: active, pixena and vload drop immediately. Timing restarts at line 0 with no glitch pulses.
- Re-run the frame-count scenario with PIX_DIV=4, COLS=40, CELL_H=10, ROWS=20: pixena count per line = 320, and vaddr wraps 19→0.

Source files
------------

// File: rtl/video_pkg.sv
// Timing constants and width helpers shared by the raster timing generator.
package video_pkg;

  // NTSC composite defaults (clock counts at the pixel clock)
  localparam int NTSC_H_TOTAL = 2038;
  localparam int NTSC_HS_WID  = 150;
  localparam int NTSC_CB_ST   = 168;
  localparam int NTSC_CB_ND   = 248;
  localparam int NTSC_ASTART  = 371;
  localparam int NTSC_PIX_DIV = 6;
  localparam int NTSC_CELL_W  = 8;
  localparam int NTSC_COLS    = 32;
  localparam int NTSC_CELL_H  = 8;
  localparam int NTSC_ROWS    = 25;
  localparam int NTSC_V_TOTAL = 262;
  localparam int NTSC_BK_TOP  = 16;
  localparam int NTSC_VS_LIN  = 248;
  localparam int NTSC_VS_WID  = 1888;

  // PAL-60 alternate set: PAL subcarrier line length with 60 Hz field geometry
  localparam int PAL60_H_TOTAL = 2270;
  localparam int PAL60_HS_WID  = 167;
  localparam int PAL60_CB_ST   = 190;
  localparam int PAL60_CB_ND   = 268;
  localparam int PAL60_ASTART  = 420;
  localparam int PAL60_PIX_DIV = 6;
  localparam int PAL60_CELL_W  = 8;
  localparam int PAL60_COLS    = 32;
  localparam int PAL60_CELL_H  = 8;
  localparam int PAL60_ROWS    = 25;
  localparam int PAL60_V_TOTAL = 262;
  localparam int PAL60_BK_TOP  = 16;
  localparam int PAL60_VS_LIN  = 248;
  localparam int PAL60_VS_WID  = 2100;

  // Bits needed to hold 0..n-1, never less than one bit
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/video_cell_addr.sv
// Pixel divider, cell column counter and cell row/line addressing.
module video_cell_addr
  import video_pkg::*;
#(
  parameter int PIX_DIV = NTSC_PIX_DIV,
  parameter int CELL_W  = NTSC_CELL_W,
  parameter int COLS    = NTSC_COLS,
  parameter int CELL_H  = NTSC_CELL_H,
  parameter int ROWS    = NTSC_ROWS,
  parameter int HA_W    = cnt_w(COLS),
  parameter int CL_W    = cnt_w(CELL_H),
  parameter int VA_W    = cnt_w(ROWS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            at_astart,  // current count is the first active clock position
  input  logic            act,        // current count lies inside the active window
  input  logic            line_end,   // last clock of an active line
  input  logic            v_first,    // first clock of the first active line
  input  logic [VA_W-1:0] row_sh,
  output logic            pixena,
  output logic            vload,
  output logic [HA_W-1:0] haddr,
  output logic [CL_W-1:0] cline,
  output logic [VA_W-1:0] vaddr
);

  localparam int DC_W = cnt_w(PIX_DIV);
  localparam int PC_W = cnt_w(CELL_W);

  logic [DC_W-1:0] dcnt_q, dcnt_d, dc;
  logic [PC_W-1:0] pcnt_q, pcnt_d, pc;
  logic [HA_W-1:0] hcell_q, hcell_d, hc;
  logic            pixena_q, pixena_d, vload_q, vload_d;
  logic [HA_W-1:0] haddr_q, haddr_d;
  logic [CL_W-1:0] cline_q, cline_d;
  logic [VA_W-1:0] vaddr_q, vaddr_d;
  logic            last_pix, last_pc;

  // Row index advance modulo ROWS (ROWS need not be a power of two)
  function automatic logic [VA_W-1:0] row_inc(input logic [VA_W-1:0] r);
    return (int'(r) >= ROWS - 1) ? '0 : r + VA_W'(1);
  endfunction

  // Divider/pixel/column counters restart at ASTART; addresses hold outside active
  always_comb begin
    dc       = at_astart ? '0 : dcnt_q;
    pc       = at_astart ? '0 : pcnt_q;
    hc       = at_astart ? '0 : hcell_q;
    last_pix = (int'(dc) == PIX_DIV - 1);
    last_pc  = (int'(pc) == CELL_W - 1);
    dcnt_d   = last_pix ? '0 : dc + DC_W'(1);
    pcnt_d   = pc;
    hcell_d  = hc;
    if (last_pix) begin
      pcnt_d = last_pc ? '0 : pc + PC_W'(1);
      if (last_pc) hcell_d = (int'(hc) == COLS - 1) ? '0 : hc + HA_W'(1);
    end
    pixena_d = act && (dc == '0);
    vload_d  = act && (dc == '0) && (pc == '0);
    haddr_d  = act ? hc : haddr_q;
    cline_d  = cline_q;
    vaddr_d  = vaddr_q;
    if (v_first) begin
      cline_d = '0;
      vaddr_d = row_sh;
    end else if (line_end) begin
      if (int'(cline_q) == CELL_H - 1) begin
        cline_d = '0;
        vaddr_d = row_inc(vaddr_q);
      end else begin
        cline_d = cline_q + CL_W'(1);
      end
    end
  end

  // Counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt_q   <= '0;
      pcnt_q   <= '0;
      hcell_q  <= '0;
      pixena_q <= 1'b0;
      vload_q  <= 1'b0;
      haddr_q  <= '0;
      cline_q  <= '0;
      vaddr_q  <= '0;
    end else begin
      dcnt_q   <= dcnt_d;
      pcnt_q   <= pcnt_d;
      hcell_q  <= hcell_d;
      pixena_q <= pixena_d;
      vload_q  <= vload_d;
      haddr_q  <= haddr_d;
      cline_q  <= cline_d;
      vaddr_q  <= vaddr_d;
    end
  end

  assign pixena = pixena_q;
  assign vload  = vload_q;
  assign haddr  = haddr_q;
  assign cline  = cline_q;
  assign vaddr  = vaddr_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster H/V timing generator with optional interlace and per-field row scroll.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_TOTAL = NTSC_H_TOTAL,
  parameter int HS_WID  = NTSC_HS_WID,
  parameter int CB_ST   = NTSC_CB_ST,
  parameter int CB_ND   = NTSC_CB_ND,
  parameter int ASTART  = NTSC_ASTART,
  parameter int PIX_DIV = NTSC_PIX_DIV,
  parameter int CELL_W  = NTSC_CELL_W,
  parameter int COLS    = NTSC_COLS,
  parameter int CELL_H  = NTSC_CELL_H,
  parameter int ROWS    = NTSC_ROWS,
  parameter int V_TOTAL = NTSC_V_TOTAL,
  parameter int BK_TOP  = NTSC_BK_TOP,
  parameter int VS_LIN  = NTSC_VS_LIN,
  parameter int VS_WID  = NTSC_VS_WID,
  parameter int HA_W    = cnt_w(COLS),
  parameter int CL_W    = cnt_w(CELL_H),
  parameter int VA_W    = cnt_w(ROWS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            interlace,
  input  logic [VA_W-1:0] start_row,
  output logic            hs_n,
  output logic            vs_n,
  output logic            cb,
  output logic            active,
  output logic            pixena,
  output logic            vload,
  output logic [HA_W-1:0] haddr,
  output logic [CL_W-1:0] cline,
  output logic [VA_W-1:0] vaddr,
  output logic            field,
  output logic            line_start,
  output logic            frame_start
);

  localparam int HC_W   = cnt_w(H_TOTAL);
  localparam int VC_W   = cnt_w(V_TOTAL + 1);
  localparam int AW     = COLS * CELL_W * PIX_DIV;
  localparam int NLINES = ROWS * CELL_H;

  if (ASTART + AW > H_TOTAL) begin : g_bad_h
    $error("active window runs past the end of the line");
  end
  if (BK_TOP + NLINES > VS_LIN) begin : g_bad_v
    $error("active lines overlap the vsync line");
  end
  if (CB_ND > ASTART) begin : g_bad_cb
    $error("colorburst overlaps active video");
  end
  if (PIX_DIV < 2) begin : g_bad_div
    $error("pixel divider must be at least 2");
  end

  logic [HC_W-1:0] hcnt_q, hcnt_d;
  logic [VC_W-1:0] vcnt_q, vcnt_d;
  logic            field_q, field_d;
  logic            il_sh_q, il_sh_d;
  logic [VA_W-1:0] row_sh_q, row_sh_d, row_ld;
  logic            hs_n_q, hs_n_d, vs_n_q, vs_n_d, cb_q, cb_d;
  logic            active_q, active_d, ls_q, ls_d, fs_q, fs_d;
  logic            h_wrap, v_wrap, v_act, h_act, at_astart, line_end, v_first;
  int              vmax;

  // Counters, field wrap and shadow loads
  always_comb begin
    vmax     = field_q ? V_TOTAL : V_TOTAL - 1;
    h_wrap   = (int'(hcnt_q) == H_TOTAL - 1);
    v_wrap   = h_wrap && (int'(vcnt_q) == vmax);
    // start_row is at most 2*ROWS-1, so one conditional subtract reduces it
    row_ld   = (int'(start_row) >= ROWS) ? VA_W'(int'(start_row) - ROWS) : start_row;
    hcnt_d   = h_wrap ? '0 : hcnt_q + HC_W'(1);
    vcnt_d   = vcnt_q;
    field_d  = field_q & il_sh_q;
    il_sh_d  = il_sh_q;
    row_sh_d = row_sh_q;
    if (h_wrap) vcnt_d = v_wrap ? '0 : vcnt_q + VC_W'(1);
    if (v_wrap) begin
      il_sh_d  = interlace;
      row_sh_d = row_ld;
      field_d  = interlace & ~field_q;
    end
  end

  // Timing decodes of the current count, registered one clock later
  always_comb begin
    hs_n_d    = !(int'(hcnt_q) < HS_WID);
    vs_n_d    = !((int'(vcnt_q) == VS_LIN) && (int'(hcnt_q) < VS_WID));
    cb_d      = (int'(hcnt_q) >= CB_ST) && (int'(hcnt_q) < CB_ND);
    ls_d      = (hcnt_q == '0);
    fs_d      = (hcnt_q == '0) && (vcnt_q == '0);
    v_act     = (int'(vcnt_q) >= BK_TOP) && (int'(vcnt_q) < BK_TOP + NLINES);
    h_act     = (int'(hcnt_q) >= ASTART) && (int'(hcnt_q) < ASTART + AW);
    active_d  = v_act && h_act;
    at_astart = (int'(hcnt_q) == ASTART);
    line_end  = v_act && h_wrap;
    v_first   = (int'(vcnt_q) == BK_TOP) && (hcnt_q == '0);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      field_q  <= 1'b0;
      il_sh_q  <= 1'b0;
      row_sh_q <= '0;
      hs_n_q   <= 1'b1;
      vs_n_q   <= 1'b1;
      cb_q     <= 1'b0;
      active_q <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      field_q  <= field_d;
      il_sh_q  <= il_sh_d;
      row_sh_q <= row_sh_d;
      hs_n_q   <= hs_n_d;
      vs_n_q   <= vs_n_d;
      cb_q     <= cb_d;
      active_q <= active_d;
      ls_q     <= ls_d;
      fs_q     <= fs_d;
    end
  end

  video_cell_addr #(
    .PIX_DIV(PIX_DIV), .CELL_W(CELL_W), .COLS(COLS), .CELL_H(CELL_H), .ROWS(ROWS),
    .HA_W(HA_W), .CL_W(CL_W), .VA_W(VA_W)
  ) u_cell (
    .clk      (clk),
    .rst_n    (reset),
    .at_astart(at_astart),
    .act      (active_d),
    .line_end (line_end),
    .v_first  (v_first),
    .row_sh   (row_sh_q),
    .pixena   (pixena),
    .vload    (vload),
    .haddr    (haddr),
    .cline    (cline),
    .vaddr    (vaddr)
  );

  assign hs_n        = hs_n_q;
  assign vs_n        = vs_n_q;
  assign cb          = cb_q;
  assign active      = active_q;
  assign field       = field_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: reduced geometry, arithmetic reference model, per-cycle compare.
module tb_video_timing_gen;

  localparam int H_TOTAL = 64;
  localparam int HS_WID  = 6;
  localparam int CB_ST   = 8;
  localparam int CB_ND   = 12;
  localparam int ASTART  = 16;
  localparam int PIX_DIV = 2;
  localparam int CELL_W  = 4;
  localparam int COLS    = 5;
  localparam int CELL_H  = 3;
  localparam int ROWS    = 5;
  localparam int V_TOTAL = 30;
  localparam int BK_TOP  = 4;
  localparam int VS_LIN  = 22;
  localparam int VS_WID  = 50;
  localparam int HA_W    = video_pkg::cnt_w(COLS);
  localparam int CL_W    = video_pkg::cnt_w(CELL_H);
  localparam int VA_W    = video_pkg::cnt_w(ROWS);
  localparam int AW      = COLS * CELL_W * PIX_DIV;
  localparam int CELLCLK = CELL_W * PIX_DIV;
  localparam int NLINES  = ROWS * CELL_H;

  typedef struct packed {
    logic hs_n, vs_n, cb, active, pixena, vload;
    logic [HA_W-1:0] haddr;
    logic [CL_W-1:0] cline;
    logic [VA_W-1:0] vaddr;
    logic field, line_start, frame_start;
  } obs_t;

  logic clk = 0, rst_n;
  logic interlace;
  logic [VA_W-1:0] start_row;
  logic hs_n, vs_n, cb, active, pixena, vload, field, line_start, frame_start;
  logic [HA_W-1:0] haddr;
  logic [CL_W-1:0] cline;
  logic [VA_W-1:0] vaddr;
  obs_t dut_o, rst_o;

  int n_chk = 0, n_fail = 0;
  obs_t expq[$];

  // model state: (mv, mh) is the count the next clock edge will process
  int mh, mv, mfield, mil, mrow, hold_ha, hold_cl, hold_va;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_TOTAL(H_TOTAL), .HS_WID(HS_WID), .CB_ST(CB_ST), .CB_ND(CB_ND), .ASTART(ASTART),
    .PIX_DIV(PIX_DIV), .CELL_W(CELL_W), .COLS(COLS), .CELL_H(CELL_H), .ROWS(ROWS),
    .V_TOTAL(V_TOTAL), .BK_TOP(BK_TOP), .VS_LIN(VS_LIN), .VS_WID(VS_WID)
  ) dut (
    .clk(clk), .reset(rst_n), .interlace(interlace), .start_row(start_row),
    .hs_n(hs_n), .vs_n(vs_n), .cb(cb), .active(active), .pixena(pixena), .vload(vload),
    .haddr(haddr), .cline(cline), .vaddr(vaddr), .field(field),
    .line_start(line_start), .frame_start(frame_start)
  );

  assign dut_o = {hs_n, vs_n, cb, active, pixena, vload, haddr, cline, vaddr,
                  field, line_start, frame_start};

  task automatic chk_int(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_obs(input string nm, input obs_t got, input obs_t exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mh = 0; mv = 0; mfield = 0; mil = 0; mrow = 0;
    hold_ha = 0; hold_cl = 0; hold_va = 0;
  endtask

  // Expected outputs from geometry arithmetic, then advance the raster position
  task automatic model_step();
    obs_t e;
    int lv, ha, k, flen;
    bit vact, act;
    lv   = mv - BK_TOP;
    ha   = mh - ASTART;
    vact = (lv >= 0) && (lv < NLINES);
    act  = vact && (ha >= 0) && (ha < AW);
    e = '0;
    e.hs_n        = !(mh < HS_WID);
    e.vs_n        = !(mv == VS_LIN && mh < VS_WID);
    e.cb          = (mh >= CB_ST) && (mh < CB_ND);
    e.line_start  = (mh == 0);
    e.frame_start = (mh == 0) && (mv == 0);
    e.active      = act;
    e.pixena      = act && (ha % PIX_DIV == 0);
    e.vload       = act && (ha % CELLCLK == 0);
    if (act) hold_ha = ha / CELLCLK;
    if (vact) begin
      k       = lv + ((mh == H_TOTAL - 1) ? 1 : 0);
      hold_cl = k % CELL_H;
      hold_va = (mrow + k / CELL_H) % ROWS;
    end
    e.haddr = HA_W'(hold_ha);
    e.cline = CL_W'(hold_cl);
    e.vaddr = VA_W'(hold_va);
    flen = mfield ? V_TOTAL + 1 : V_TOTAL;
    if (mh == H_TOTAL - 1) begin
      mh = 0;
      if (mv == flen - 1) begin
        mv     = 0;
        mil    = int'(interlace);
        mrow   = int'(start_row) % ROWS;
        mfield = mil ? (mfield ^ 1) : 0;
      end else mv++;
    end else mh++;
    e.field = mfield[0];
    expq.push_back(e);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Monitor: reset-state check while in reset, scoreboard pop per clock otherwise
  initial begin
    obs_t e;
    int l_act, l_pix, l_vl, n_lines;
    bit full_fld;
    rst_o = '0; rst_o.hs_n = 1'b1; rst_o.vs_n = 1'b1;
    l_act = 0; l_pix = 0; l_vl = 0; n_lines = 0; full_fld = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        expq.delete();
        chk_obs("reset_state", dut_o, rst_o);
        l_act = 0; l_pix = 0; l_vl = 0; n_lines = 0; full_fld = 0;
      end else if (expq.size() > 0) begin
        e = expq.pop_front();
        chk_obs("cycle", dut_o, e);
        if (line_start) begin
          if (l_act != 0) begin
            chk_int("line_active_clks", l_act, AW);
            chk_int("line_pixena", l_pix, COLS * CELL_W);
            chk_int("line_vload", l_vl, COLS);
            n_lines++;
          end
          if (frame_start) begin
            if (full_fld) chk_int("field_active_lines", n_lines, NLINES);
            full_fld = 1; n_lines = 0;
          end
          l_act = 0; l_pix = 0; l_vl = 0;
        end
        l_act += int'(active); l_pix += int'(pixena); l_vl += int'(vload);
      end
    end
  end

  task automatic wait_pos(input int v, input int h);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(mv == v && mh == h) && n < 5000);
    if (!(mv == v && mh == h)) begin
      n_chk++; n_fail++;
      $display("FAIL wait_pos: line %0d clk %0d not reached within %0d clocks", v, h, n);
    end
  endtask

  task automatic wait_wrap();
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(mh == H_TOTAL - 1 && mv == (mfield ? V_TOTAL : V_TOTAL - 1)) && n < 5000);
    if (n >= 5000) begin
      n_chk++; n_fail++;
      $display("FAIL wait_wrap: no field wrap within %0d clocks", n);
    end
  endtask

  // Called on a frame_start sample; returns lines up to the next frame_start
  task automatic count_lines(output int n);
    int b = 0;
    n = 1;
    forever begin
      @(negedge clk); b++;
      if (frame_start || b > 5000) break;
      if (line_start) n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 0; interlace = 0; start_row = '0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    chk_int("first_strobe", {line_start, frame_start}, 3);
    count_lines(n); chk_int("field_len_ni", n, V_TOTAL);

    // shadow load on the wrap clock is taken, one clock later waits a field
    wait_wrap(); start_row = VA_W'(ROWS - 1);
    @(negedge clk); start_row = VA_W'(2);
    wait_pos(BK_TOP + 1, 0);      chk_int("scroll_taken", int'(vaddr), ROWS - 1);
    wait_pos(BK_TOP + CELL_H, 1); chk_int("scroll_wrap", int'(vaddr), 0);
    wait_pos(BK_TOP + 1, 0);      chk_int("scroll_late", int'(vaddr), 2);
    wait_pos(BK_TOP + 5, 0);      start_row = VA_W'(4);
    wait_pos(BK_TOP + NLINES, 0); chk_int("midfield_hold", int'(vaddr), 2);
    wait_pos(BK_TOP + 1, 0);      chk_int("next_field_row", int'(vaddr), 4);

    // interlace on: alternating field lengths, then off again
    wait_pos(10, 0); interlace = 1;
    wait_wrap(); @(negedge clk);
    chk_int("field_toggle", int'(field), 1);
    @(negedge clk);
    count_lines(n); chk_int("field1_len", n, V_TOTAL + 1);
    count_lines(n); chk_int("field0_len", n, V_TOTAL);
    count_lines(n); chk_int("field1_len_b", n, V_TOTAL + 1);
    wait_pos(12, 0); interlace = 0;
    wait_wrap(); @(negedge clk);
    chk_int("field_clear", int'(field), 0);
    @(negedge clk);
    count_lines(n); chk_int("field_len_after", n, V_TOTAL);

    // asynchronous reset in the middle of an active line
    wait_pos(BK_TOP + 5, ASTART + 14);
    #2 rst_n = 0;
    #1 chk_int("async_rst_drop", {active, pixena, vload}, 0);
    chk_int("async_rst_sync", {hs_n, vs_n, line_start, frame_start}, 12);
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    chk_int("restart_strobe", {line_start, frame_start}, 3);
    count_lines(n); chk_int("field_len_restart", n, V_TOTAL);

    // randomized input activity
    repeat (12000) begin
      @(negedge clk);
      if ($urandom_range(0, 299) == 0) start_row = VA_W'($urandom_range(0, ROWS - 1));
      if ($urandom_range(0, 2999) == 0) interlace = ~interlace;
    end
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
